// File: rtl/instr_ctrl.sv
// instr_ctrl: multi-cycle fetch/decode/control sequencer for the 16-bit datapath.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | read instruction at PC into isr, PC+1 when memory is ready
// DECODE  | classify isr, trap illegal opcodes
// EXEC    | ALU/BR complete; stack ops pre-decrement SP or read stack
// EXEC2   | push/call write the stack; pop/ret post-increment SP
// HALT    | parked until reset
module instr_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      memout,
  input  logic             mrdy,
  output logic [15:0]      isr,
  output logic             regw,
  output logic             wsel,
  output logic             memw,
  output logic [1:0]       memin,
  output logic             sflag,
  output logic [1:0]       spi,
  output logic             pcen,
  output logic             pcin,
  output logic             pci,
  output logic             marsel,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_EXEC2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state;

  logic [1:0] cls;
  logic [1:0] sub;
  logic [2:0] funsel;
  logic is_alu, is_br, is_push, is_pushi, is_call, is_pop, is_ret, is_halt, is_ill;

  assign cls      = isr[15:14];
  assign sub      = isr[13:12];
  assign funsel   = isr[13:11];
  assign is_alu   = (cls == 2'b00);
  assign is_br    = (cls == 2'b01);
  assign is_push  = (cls == 2'b10) && (sub == 2'b00);
  assign is_pushi = (cls == 2'b10) && (sub == 2'b01);
  assign is_call  = (cls == 2'b10) && (sub == 2'b10);
  assign is_pop   = (cls == 2'b11) && (sub == 2'b00);
  assign is_ret   = (cls == 2'b11) && (sub == 2'b01);
  assign is_halt  = (cls == 2'b11) && (sub == 2'b10);
  assign is_ill   = (sub == 2'b11) && cls[1];

  // Sequencer state, instruction register, sticky flags and retire counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      isr     <= 16'h0000;
      halted  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mrdy) begin
            isr   <= memout;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_ill) begin
            illegal <= 1'b1;
            if (HALT_ON_ILLEGAL) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_alu || is_br) begin
            retired <= retired + CNT_W'(1);
            state   <= S_FETCH;
          end else if (is_push || is_pushi || is_call) begin
            state <= S_EXEC2;
          end else if (is_pop || is_ret) begin
            if (mrdy) state <= S_EXEC2;
          end else if (is_halt) begin
            retired <= retired + CNT_W'(1);
            halted  <= 1'b1;
            state   <= S_HALT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_EXEC2: begin
          retired <= retired + CNT_W'(1);
          state   <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Datapath strobes; forced low while reset is asserted so an abort is immediate.
  always_comb begin
    regw   = 1'b0;
    wsel   = 1'b0;
    memw   = 1'b0;
    memin  = 2'd0;
    sflag  = 1'b0;
    spi    = 2'd0;
    pcen   = 1'b0;
    pcin   = 1'b0;
    pci    = 1'b0;
    marsel = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          if (mrdy) begin
            pcen = 1'b1;
            pcin = 1'b1;
          end
        end
        S_EXEC: begin
          if (is_alu && (funsel != 3'd0)) begin
            regw  = 1'b1;
            sflag = 1'b1;
          end else if (is_br) begin
            pcen = 1'b1;
            pcin = 1'b1;
            pci  = 1'b1;
          end else if (is_push || is_pushi || is_call) begin
            spi = 2'd2;
          end else if (is_pop || is_ret) begin
            marsel = 1'b1;
            if (mrdy) begin
              regw = is_pop;
              wsel = is_pop;
              pcen = is_ret;
            end
          end
        end
        S_EXEC2: begin
          if (is_push || is_pushi || is_call) begin
            marsel = 1'b1;
            memw   = 1'b1;
            memin  = is_pushi ? 2'd2 : (is_call ? 2'd1 : 2'd0);
            pcen   = is_call;
            pcin   = is_call;
            pci    = is_call;
          end else begin
            spi = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
